upcnt_tmr: RTL and testbench
============================

# upcnt_tmr

Loadable up-counting interval timer: a WIDTH-bit ripple-carry up counter built from per-bit increment cells. It carries a reload register, a run/one-shot control state machine and a terminal-count pulse. It is the incrementing counterpart of the per-bit down-counter slices used in the video and object-processor timing chains. It serves as a programmable period and interval timer, and its carry output cascades into further counters.

## Interface
- WIDTH, 16, counter and reload width (≥2)
- clk  in  1  single system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- d  in  WIDTH  load / reload value
- ld  in  1  load strobe: q and reload register take d
- ci  in  1  count enable (carry in)
- start  in  1  start strobe, honoured in IDLE or DONE
- oneshot  in  1  1 = stop after first wrap; 0 = free-running periodic
- pre  in  8  prescale divisor minus one (only with UPCNT_PRESCALE_EN)
- q  out  WIDTH  counter value
- co  out  1  combinational carry out = tick & RUN & (q all ones)
- tc  out  1  registered one-cycle terminal-count pulse
- busy  out  1  high in RUN
- done  out  1  high in DONE

## Operation
- States: IDLE (hold), RUN (count), DONE (one-shot expired, hold).
- tick = ci, or prescaled ci (see Configuration). q increments only in RUN on tick.
- Wrap event: RUN & tick & q == all ones.
- Wrap with oneshot=0: q <= rl and state stays RUN.
- Wrap with oneshot=1: q holds all ones and state goes to DONE.
- tc is set on the same edge as a wrap and clears on the next edge, so it is exactly one cycle wide.
- ld in any state: q <= d, rl <= d, state -> IDLE. No tc is raised and the prescaler clears.
- start in IDLE: state -> RUN and q is unchanged.
- start in DONE: q <= rl and state -> RUN.
- start in RUN is ignored.
- Priority: reset > ld > wrap > start > increment.
- ld and start in the same cycle: ld wins and the block ends in IDLE.
- Arithmetic: modulo 2^WIDTH. A wrap reloads rl, never zero, unless rl = 0.
- rl = all ones with oneshot=0: a wrap occurs on every tick, giving a continuous tc pulse train at the tick rate.
- Reset values: q=0, rl=0, state IDLE, tc=0, busy=0, done=0, co=0, prescaler=0.

## Timing
- All registered outputs update one clock after the causing input edge: q, tc, busy, done.
- co is combinational from q, state and tick, with no register. It is intended as the ci of a cascaded stage in the same cycle.
- Load latency: q equals d on the edge where ld is sampled high.
- Reset asserted mid-count clears everything immediately. No tc is issued for a wrap pending in that cycle.
- Release of reset is synchronised externally. The block needs no internal reset synchroniser.

## Configuration
- UPCNT_PRESCALE_EN defined:
  - An 8-bit prescale counter advances on each ci while in RUN.
  - tick is asserted when the prescaler equals pre and ci is high; the prescaler then returns to 0. A tick therefore occurs every pre+1 enabled cycles.
  - The prescaler clears on reset, on ld, and on entry to RUN.
  - The pre port exists.
- UPCNT_PRESCALE_EN undefined: tick = ci, no prescale register, no pre port.

## Structure
- Package tom_cnt_pkg holds:
  - the state encoding typedef (IDLE=2'b00, RUN=2'b01, DONE=2'b10);
  - the WIDTH default constant;
  - the prescaler width constant (8).
- Sub-module upcnt is a one-bit slice. It contains a resettable flop, and a 2:1 mux that selects d on load or q^cin otherwise. Its carry output is cout = cin & q.
  - Instantiate WIDTH slices, chaining cout to the next slice's cin.
  - The top-level FSM drives the slice load and carry-in: the load value is rl on reload, and the first slice's cin is tick & RUN.

## Test plan
- Reset: assert reset mid-RUN with q=0x1234 -> q=0, busy=0, done=0, tc=0 immediately, without waiting for a clock.
- Periodic, WIDTH=4: ld d=0xC, start, ci=1, oneshot=0 -> q counts C,D,E,F,C,D… The tc pulse is one cycle wide on each F->C edge, every 4 clocks.
- One-shot: ld d=0xE, oneshot=1, start, ci=1 -> q goes E,F. Then done=1, busy=0 and q holds F with a single tc pulse. A further start gives q=E and RUN again.
- Collisions: ld d=0x3 on the same edge as a wrap -> q=3, IDLE, tc=0. ld and start together -> IDLE, q=d.
- Cascade: co observed high only when q=all ones, ci=1 and RUN. With ci=0 at q=F -> co=0 and q holds.
- UPCNT_PRESCALE_EN, pre=2: ci held high in RUN -> q increments every 3rd clock. ld clears the prescaler, so the first increment after start occurs 3 clocks later.

Source files
------------

// File: rtl/tom_cnt_pkg.sv
// rtl/tom_cnt_pkg.sv - shared types and constants for the up-counting interval timer
package tom_cnt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int CNT_WIDTH_DEFAULT = 16;
  localparam int PRESCALE_WIDTH    = 8;

endpackage

// File: rtl/upcnt.sv
// rtl/upcnt.sv - one-bit loadable increment slice with ripple carry
module upcnt (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic d,
  input  logic cin,
  output logic q,
  output logic cout
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      q <= 1'b0;
    else
      q <= load ? d : (q ^ cin);
  end

  assign cout = cin & q;

endmodule

// File: rtl/upcnt_tmr.sv
// rtl/upcnt_tmr.sv - loadable up-counting interval timer with run/one-shot control
// Optional prescaler enabled by defining UPCNT_PRESCALE_EN.
module upcnt_tmr
  import tom_cnt_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          d,
  input  logic                      ld,
  input  logic                      ci,
  input  logic                      start,
  input  logic                      oneshot,
`ifdef UPCNT_PRESCALE_EN
  input  logic [PRESCALE_WIDTH-1:0] pre,
`endif
  output logic [WIDTH-1:0]          q,
  output logic                      co,
  output logic                      tc,
  output logic                      busy,
  output logic                      done
);

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   rl;
  logic [WIDTH-1:0]   load_val;
  logic [WIDTH:0]     carry;
  logic               tick;
  logic               run;
  logic               wrap;
  logic               load;

  assign run = (state == ST_RUN);

`ifdef UPCNT_PRESCALE_EN
  logic [PRESCALE_WIDTH-1:0] ps;
  logic                      run_entry;

  assign run_entry = (state != ST_RUN) && (state_nxt == ST_RUN);
  assign tick      = ci && (ps == pre);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ps <= '0;
    else if (ld || run_entry)
      ps <= '0;
    else if (run && ci)
      ps <= (ps == pre) ? '0 : ps + 1'b1;
  end
`else
  assign tick = ci;
`endif

  // The ripple carry out of the top slice is exactly the wrap condition.
  assign carry[0] = tick & run;
  assign wrap     = carry[WIDTH];
  assign co       = carry[WIDTH];

  assign load = ld | wrap | (start && state == ST_DONE);

  always_comb begin
    load_val = rl;
    if (ld)
      load_val = d;
    else if (wrap && oneshot)
      load_val = '1;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    upcnt u_bit (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .d     (load_val[i]),
      .cin   (carry[i]),
      .q     (q[i]),
      .cout  (carry[i+1])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rl <= '0;
    else if (ld)
      rl <= d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      tc <= 1'b0;
    else
      tc <= wrap & ~ld;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (ld)
      state_nxt = ST_IDLE;
    else if (wrap)
      state_nxt = oneshot ? ST_DONE : ST_RUN;
    else begin
      case (state)
        ST_IDLE: if (start) state_nxt = ST_RUN;
        ST_DONE: if (start) state_nxt = ST_RUN;
        ST_RUN:  state_nxt = ST_RUN;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ST_RUN:  busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_upcnt_tmr.sv
// tb/tb_upcnt_tmr.sv - self-checking bench for upcnt_tmr at WIDTH=4
module tb_upcnt_tmr;

  localparam int W  = 4;
  localparam int NV = 29;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] d;
  logic         ld, ci, start, oneshot;
  logic [W-1:0] q;
  logic         co, tc, busy, done;
`ifdef UPCNT_PRESCALE_EN
  logic [7:0]   pre;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  upcnt_tmr #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .d       (d),
    .ld      (ld),
    .ci      (ci),
    .start   (start),
    .oneshot (oneshot),
`ifdef UPCNT_PRESCALE_EN
    .pre     (pre),
`endif
    .q       (q),
    .co      (co),
    .tc      (tc),
    .busy    (busy),
    .done    (done)
  );

  typedef struct {
    logic         ld;
    logic [W-1:0] d;
    logic         start;
    logic         ci;
    logic         os;
    logic         co;
    logic [W-1:0] q;
    logic         tc;
    logic         busy;
    logic         done;
  } vec_t;

  typedef struct {
    logic [W-1:0] q;
    logic         tc;
    logic         busy;
    logic         done;
    int           idx;
  } exp_t;

  vec_t vecs [NV];
  exp_t sb [$];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    exp_t e;

    //             ld  d     st  ci  os  co   q     tc  busy done
    vecs[0]  = '{1, 4'hC, 0, 0, 0, 0, 4'hC, 0, 0, 0};
    vecs[1]  = '{0, 4'h0, 1, 0, 0, 0, 4'hC, 0, 1, 0};
    vecs[2]  = '{0, 4'h0, 0, 1, 0, 0, 4'hD, 0, 1, 0};
    vecs[3]  = '{0, 4'h0, 0, 1, 0, 0, 4'hE, 0, 1, 0};
    vecs[4]  = '{0, 4'h0, 0, 1, 0, 0, 4'hF, 0, 1, 0};
    vecs[5]  = '{0, 4'h0, 0, 1, 0, 1, 4'hC, 1, 1, 0};
    vecs[6]  = '{0, 4'h0, 0, 1, 0, 0, 4'hD, 0, 1, 0};
    vecs[7]  = '{0, 4'h0, 0, 1, 0, 0, 4'hE, 0, 1, 0};
    vecs[8]  = '{0, 4'h0, 0, 1, 0, 0, 4'hF, 0, 1, 0};
    vecs[9]  = '{0, 4'h0, 0, 1, 0, 1, 4'hC, 1, 1, 0};
    vecs[10] = '{0, 4'h0, 0, 0, 0, 0, 4'hC, 0, 1, 0};
    vecs[11] = '{0, 4'h0, 0, 1, 0, 0, 4'hD, 0, 1, 0};
    vecs[12] = '{0, 4'h0, 0, 1, 0, 0, 4'hE, 0, 1, 0};
    vecs[13] = '{0, 4'h0, 0, 1, 0, 0, 4'hF, 0, 1, 0};
    vecs[14] = '{0, 4'h0, 0, 0, 0, 0, 4'hF, 0, 1, 0};
    vecs[15] = '{1, 4'h3, 0, 1, 0, 1, 4'h3, 0, 0, 0};
    vecs[16] = '{1, 4'hE, 0, 0, 1, 0, 4'hE, 0, 0, 0};
    vecs[17] = '{0, 4'h0, 1, 1, 1, 0, 4'hE, 0, 1, 0};
    vecs[18] = '{0, 4'h0, 0, 1, 1, 0, 4'hF, 0, 1, 0};
    vecs[19] = '{0, 4'h0, 0, 1, 1, 1, 4'hF, 1, 0, 1};
    vecs[20] = '{0, 4'h0, 0, 1, 1, 0, 4'hF, 0, 0, 1};
    vecs[21] = '{0, 4'h0, 1, 0, 1, 0, 4'hE, 0, 1, 0};
    vecs[22] = '{1, 4'h5, 1, 0, 0, 0, 4'h5, 0, 0, 0};
    vecs[23] = '{0, 4'h0, 1, 1, 0, 0, 4'h5, 0, 1, 0};
    vecs[24] = '{1, 4'hF, 0, 0, 0, 0, 4'hF, 0, 0, 0};
    vecs[25] = '{0, 4'h0, 1, 0, 0, 0, 4'hF, 0, 1, 0};
    vecs[26] = '{0, 4'h0, 0, 1, 0, 1, 4'hF, 1, 1, 0};
    vecs[27] = '{0, 4'h0, 0, 1, 0, 1, 4'hF, 1, 1, 0};
    vecs[28] = '{0, 4'h0, 0, 0, 0, 0, 4'hF, 0, 1, 0};

    reset = 1'b1; d = '0; ld = 0; ci = 0; start = 0; oneshot = 0;
`ifdef UPCNT_PRESCALE_EN
    pre = 8'd0;
`endif
    #2;
    check("rst_q",    0, q,    0);
    check("rst_tc",   0, tc,   0);
    check("rst_busy", 0, busy, 0);
    check("rst_done", 0, done, 0);
    check("rst_co",   0, co,   0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      ld = vecs[i].ld; d = vecs[i].d; start = vecs[i].start;
      ci = vecs[i].ci; oneshot = vecs[i].os;
      sb.push_back('{vecs[i].q, vecs[i].tc, vecs[i].busy, vecs[i].done, i});
      #1;
      check("co", i, co, vecs[i].co);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty[%0d]: got 0 entries expected 1", i);
      end else begin
        e = sb.pop_front();
        check("q",    e.idx, q,    e.q);
        check("tc",   e.idx, tc,   e.tc);
        check("busy", e.idx, busy, e.busy);
        check("done", e.idx, done, e.done);
      end
    end

    // Asynchronous reset while tc is high and a wrap is pending.
    @(negedge clk);
    ld = 1; d = 4'hF; start = 0; ci = 0; oneshot = 0;
    @(negedge clk);
    ld = 0; start = 1;
    @(negedge clk);
    start = 0; ci = 1;
    @(posedge clk);
    #1;
    check("pre_rst_tc",   100, tc,   1);
    check("pre_rst_busy", 100, busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_q",    101, q,    0);
    check("async_tc",   101, tc,   0);
    check("async_busy", 101, busy, 0);
    check("async_done", 101, done, 0);
    check("async_co",   101, co,   0);
    @(negedge clk);
    ci = 0;
    @(negedge clk);
    reset = 1'b0;

`ifdef UPCNT_PRESCALE_EN
    @(negedge clk);
    pre = 8'd2; ld = 1; d = 4'h0;
    @(negedge clk);
    ld = 0; start = 1; ci = 1;
    @(posedge clk);
    #1;
    check("ps_start_q", 200, q, 0);
    @(negedge clk);
    start = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      check("ps_q", 200 + k, q, k / 3);
    end
    ci = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
